reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Staged reset controller that follows the synchronized system reset and clock-lock status.
- Releases the downstream resets one by one, in fixed order. Order: clock/DCM consumers, ADC capture, sample RAM, VGA display.
- Each release waits for that stage's ready acknowledge plus a settle gap before the next stage is released.
- Provides the single "system ready" indication and a fault report for a stage that never acknowledges.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; index 0 is released first.
- HOLD_CYCLES, 16: qualifying cycles (lock high, no soft request) required before stage 0 is released; must be ≥1.
- STAGE_GAP, 8: settle cycles after an acknowledge before the next release; 0 means release on the acknowledge edge.
- ACK_TIMEOUT, 4096: maximum wait for an acknowledge, in cycles. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock (buffered 12 MHz domain).
- rst_i  in  1  synchronous, active-high reset.
- lock_i  in  1  DCM locked, already synchronized to clk_i.
- req_rst_i  in  1  soft reset request, level-sensitive, active-high.
- stage_ack_i  in  NUM_STAGES  per-stage ready; bit k is meaningful only once stage k is released.
- stage_rst_o  out  NUM_STAGES  per-stage active-high reset, registered.
- all_ready_o  out  1  high only in RUN.
- busy_o  out  1  high whenever not in RUN and not in FAULT.
- fault_o  out  1  high in FAULT, sticky.
- fault_stage_o  out  clog2(NUM_STAGES) (minimum 1)  index of the stage that timed out.

Behaviour:
- Reset: rst_i high at an edge causes the following state on that edge:
  - state ASSERT, stage index 0, counter 0
  - stage_rst_o all ones
  - all_ready_o 0, busy_o 1, fault_o 0, fault_stage_o 0
- Abort rule: in every state except FAULT, sampling lock_i=0 or req_rst_i=1 causes the following on the next edge:
  - state becomes ASSERT
  - counter and index clear
  - stage_rst_o all ones, all_ready_o 0
- In FAULT, only req_rst_i=1 or rst_i exits to ASSERT. Loss of lock does not clear the fault.
- ASSERT:
  - The counter increments on each qualifying edge (lock_i=1, req_rst_i=0).
  - A non-qualifying cycle clears the counter.
  - On the edge where the count reaches HOLD_CYCLES, go to WAIT_ACK and clear stage_rst_o[0] on that edge.
  - Stage 0 therefore releases exactly HOLD_CYCLES edges after the first qualifying edge.
- WAIT_ACK(idx):
  - The acknowledge is sampled starting from the first edge after release.
  - On the edge where stage_ack_i[idx]=1:
    - If idx=NUM_STAGES-1: go to RUN, all_ready_o=1 and busy_o=0 on that edge.
    - Else if STAGE_GAP=0: idx+1, clear stage_rst_o[idx+1] on that edge, stay in WAIT_ACK.
    - Else: go to GAP with the counter at 0.
- GAP: counts STAGE_GAP edges. On the last one, idx+1, clear stage_rst_o[idx+1], return to WAIT_ACK.
- Ordering invariants:
  - Released stages stay released until an abort.
  - Unreleased stages stay in reset.
  - Acknowledges from unreleased stages are ignored.
- RUN: hold all stage_rst_o=0. Any released-stage acknowledge dropping to 0 counts as an abort and returns the block to ASSERT.
- Simultaneous events: abort beats acknowledge and beats counter completion. rst_i beats everything.
- Counter width: clog2(max(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT)+1). The counter saturates and never wraps.

Optional Feature:
- Macro: RESET_SEQUENCER_TIMEOUT_EN.
- Defined:
  - The counter also runs in WAIT_ACK.
  - If ACK_TIMEOUT edges pass without an acknowledge, go to FAULT with fault_o=1 and fault_stage_o=idx.
  - stage_rst_o returns to all ones, busy_o=0.
  - An acknowledge arriving on the timeout edge wins.
- Undefined:
  - WAIT_ACK waits indefinitely and FAULT is unreachable.
  - fault_o and fault_stage_o are tied to 0, and the ACK_TIMEOUT parameter is ignored.

Decomposition:
- Package reset_sequencer_pkg contains:
  - state encoding (ASSERT, WAIT_ACK, GAP, RUN, FAULT)
  - clog2 helper function
  - counter-width constant function
- One sub-module, seq_counter: a synchronous clear/enable saturating up-counter with a terminal-count compare input. It is shared by the hold, gap and timeout phases.
- The FSM and the stage_rst_o register live in the top module.

Test Plan:
All scenarios use NUM_STAGES=3, HOLD_CYCLES=4, STAGE_GAP=2, ACK_TIMEOUT=16.

- Clean power-up: rst_i high then low, lock_i=1, each acknowledge raised 3 cycles after its release.
  - Expect stage_rst_o = 111 → 110 at edge 4 → 100 → 000, with 2-cycle gaps.
  - Expect all_ready_o=1 on the stage-2 acknowledge edge.
- Lock glitch in ASSERT: lock_i drops for 1 cycle at count 3.
  - Expect the count to restart and stage 0 to release 4 qualifying edges after lock returns.
- Soft reset in RUN: req_rst_i pulses for 1 cycle.
  - Expect stage_rst_o=111 and all_ready_o=0 on the next edge, then a full resequence.
- Acknowledge drop in RUN: stage_ack_i[1] falls.
  - Expect return to ASSERT with all resets asserted the next edge.
- Timeout, with the macro defined: stage 1 never acknowledges.
  - After 16 cycles in WAIT_ACK, expect fault_o=1, fault_stage_o=1, stage_rst_o=111.
  - Toggling lock_i keeps FAULT; req_rst_i exits to ASSERT.
- Timeout, macro undefined: same stimulus as the previous scenario.
  - Expect no fault after 100 cycles, busy_o=1, stage_rst_o=100.
  - A late acknowledge resumes the sequence normally.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
// Optional acknowledge timeout is enabled by RESET_SEQUENCER_TIMEOUT_EN.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT   = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_GAP      = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_stages);
        int unsigned w;
        w = clog2(num_stages);
        return (w < 1) ? 1 : w;
    endfunction

    // Wide enough to hold the largest terminal count of any phase.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned stage_gap,
                                              input int unsigned ack_timeout);
        int unsigned m;
        int unsigned w;
        m = hold_cycles;
        if (stage_gap > m) begin
            m = stage_gap;
        end
        if (ack_timeout > m) begin
            m = ack_timeout;
        end
        w = clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reset_sequencer_counter.sv
// Saturating up-counter with synchronous clear/enable and a "next edge hits
// terminal count" flag, shared by the hold, gap and timeout phases.
module seq_counter
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_tc,
    output logic             o_last_c
);

    localparam int unsigned EXT_W = WIDTH + 1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // High when the next enabled increment lands exactly on i_tc.
    assign o_last_c = ({1'b0, r_count} + EXT_W'(1)) == {1'b0, i_tc};

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases stage resets in order, each after the
// previous stage acknowledges plus a settle gap. Timeout/FAULT reporting is
// built only when RESET_SEQUENCER_TIMEOUT_EN is defined.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                lock_i,
    input  logic                                req_rst_i,
    input  logic [NUM_STAGES-1:0]               stage_ack_i,
    output logic [NUM_STAGES-1:0]               stage_rst_o,
    output logic                                all_ready_o,
    output logic                                busy_o,
    output logic                                fault_o,
    output logic [idx_width(NUM_STAGES)-1:0]    fault_stage_o
);

    localparam int unsigned IDX_W = idx_width(NUM_STAGES);
    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] ACK_TC   = CNT_W'(ACK_TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [NUM_STAGES-1:0]   r_stage_rst;
    logic [NUM_STAGES-1:0]   w_stage_rst_nxt;
    logic                    r_all_ready;
    logic                    r_busy;
    logic                    w_abort;
    logic                    w_cnt_clr;
    logic                    w_cnt_en;
    logic                    w_cnt_last;
    logic [CNT_W-1:0]        w_cnt_tc;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    logic                    r_fault;
    logic [IDX_W-1:0]        r_fault_stage;
    logic [IDX_W-1:0]        w_fault_stage_nxt;
`endif

    seq_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_tc     (w_cnt_tc),
        .o_last_c (w_cnt_last)
    );

    // Terminal count depends only on the current phase.
    always_comb begin
        w_cnt_tc = HOLD_TC;
        case (r_state)
            ST_GAP:      w_cnt_tc = GAP_TC;
            ST_WAIT_ACK: w_cnt_tc = ACK_TC;
            default:     w_cnt_tc = HOLD_TC;
        endcase
    end

    // FAULT only leaves on a soft request; RUN also aborts on any ack drop.
    always_comb begin
        w_abort = 1'b0;
        case (r_state)
            ST_FAULT: w_abort = req_rst_i;
            ST_RUN:   w_abort = !lock_i || req_rst_i || (stage_ack_i != '1);
            default:  w_abort = !lock_i || req_rst_i;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_idx_inc       = r_idx + IDX_W'(1);
        w_stage_rst_nxt = r_stage_rst;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        w_fault_stage_nxt = r_fault_stage;
`endif
        if (w_abort) begin
            w_state_nxt     = ST_ASSERT;
            w_idx_nxt       = '0;
            w_stage_rst_nxt = '1;
            w_cnt_clr       = 1'b1;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            w_fault_stage_nxt = '0;
`endif
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (w_cnt_last) begin
                        w_state_nxt        = ST_WAIT_ACK;
                        w_stage_rst_nxt[0] = 1'b0;
                        w_cnt_clr          = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (stage_ack_i[r_idx]) begin
                        w_cnt_clr = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_RUN;
                        end else if (STAGE_GAP == 0) begin
                            w_idx_nxt                  = w_idx_inc;
                            w_stage_rst_nxt[w_idx_inc] = 1'b0;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
                        if (w_cnt_last) begin
                            w_state_nxt       = ST_FAULT;
                            w_stage_rst_nxt   = '1;
                            w_fault_stage_nxt = r_idx;
                            w_idx_nxt         = '0;
                            w_cnt_clr         = 1'b1;
                        end else begin
                            w_cnt_en = 1'b1;
                        end
`endif
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) begin
                        w_state_nxt                = ST_WAIT_ACK;
                        w_idx_nxt                  = w_idx_inc;
                        w_stage_rst_nxt[w_idx_inc] = 1'b0;
                        w_cnt_clr                  = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_ASSERT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Status flags registered from the next state so they align with stage_rst_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage_rst <= '1;
            r_all_ready <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_stage_rst <= w_stage_rst_nxt;
            r_all_ready <= (w_state_nxt == ST_RUN);
            r_busy      <= (w_state_nxt != ST_RUN) && (w_state_nxt != ST_FAULT);
        end
    end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_fault       <= (w_state_nxt == ST_FAULT);
            r_fault_stage <= w_fault_stage_nxt;
        end
    end

    assign fault_o       = r_fault;
    assign fault_stage_o = r_fault_stage;
`else
    assign fault_o       = 1'b0;
    assign fault_stage_o = '0;
`endif

    assign stage_rst_o = r_stage_rst;
    assign all_ready_o = r_all_ready;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, timeout corner sequence
// and randomized run against a release-count reference model.
module tb_reset_sequencer;

    localparam int unsigned N       = 3;
    localparam int unsigned HOLD    = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned TIMEOUT = 16;

    logic         clk_i;
    logic         rst_i;
    logic         lock_i;
    logic         req_rst_i;
    logic [N-1:0] stage_ack_i;
    logic [N-1:0] stage_rst_o;
    logic         all_ready_o;
    logic         busy_o;
    logic         fault_o;
    logic [1:0]   fault_stage_o;

    reset_sequencer #(
        .NUM_STAGES  (N),
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lock_i        (lock_i),
        .req_rst_i     (req_rst_i),
        .stage_ack_i   (stage_ack_i),
        .stage_rst_o   (stage_rst_o),
        .all_ready_o   (all_ready_o),
        .busy_o        (busy_o),
        .fault_o       (fault_o),
        .fault_stage_o (fault_stage_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rst;
        logic       lock;
        logic       req;
        logic [2:0] ack;
        logic [2:0] exp_rst;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: number of released stages plus simple phase counters.
    int m_rel, m_hold, m_gap, m_wait, m_fstage;
    bit m_in_gap, m_ready, m_fault;

    function automatic void add(input logic r, input logic l, input logic q, input logic [2:0] a,
                                input logic [2:0] er, input logic erdy, input logic ebusy);
        vec_t v;
        v.rst = r; v.lock = l; v.req = q; v.ack = a;
        v.exp_rst = er; v.exp_ready = erdy; v.exp_busy = ebusy;
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] obs();
        return {stage_rst_o, all_ready_o, busy_o, fault_o, fault_stage_o};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got rst/rdy/busy/flt/stg=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic q, input logic [2:0] a);
        rst_i = r; lock_i = l; req_rst_i = q; stage_ack_i = a;
        @(posedge clk_i);
        #1;
    endtask

    function automatic void model_clear();
        m_rel = 0; m_hold = 0; m_gap = 0; m_wait = 0; m_fstage = 0;
        m_in_gap = 0; m_ready = 0; m_fault = 0;
    endfunction

    function automatic void model_step(input bit r, input bit l, input bit q, input logic [2:0] a);
        if (r) begin model_clear(); return; end
        if (m_fault) begin
            if (q) model_clear();
            return;
        end
        if (!l || q || (m_ready && a != 3'b111)) begin model_clear(); return; end
        if (m_ready) return;
        if (m_rel == 0) begin
            m_hold++;
            if (m_hold == HOLD) begin m_rel = 1; m_hold = 0; m_wait = 0; end
            return;
        end
        if (m_in_gap) begin
            m_gap++;
            if (m_gap == GAP) begin m_in_gap = 0; m_rel++; m_wait = 0; end
            return;
        end
        if (a[m_rel-1]) begin
            m_wait = 0;
            if (m_rel == N) m_ready = 1;
            else if (GAP == 0) m_rel++;
            else begin m_in_gap = 1; m_gap = 0; end
        end else begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_fault = 1; m_fstage = m_rel - 1; m_rel = 0; m_wait = 0;
            end
`endif
        end
    endfunction

    function automatic logic [7:0] model_obs();
        logic [2:0] r;
        for (int k = 0; k < N; k++) r[k] = (k >= m_rel);
        return {r, m_ready, !m_ready && !m_fault, m_fault, 2'(m_fstage)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ack_r;
        rst_i = 1'b1; lock_i = 1'b0; req_rst_i = 1'b0; stage_ack_i = '0;

        // Power-up, soft reset, lock glitch and ack drop in RUN.
        add(1,1,0,3'b000, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1); add(0,1,0,3'b000, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1); add(0,1,0,3'b000, 3'b110,0,1);
        add(0,1,0,3'b000, 3'b110,0,1); add(0,1,0,3'b000, 3'b110,0,1);
        add(0,1,0,3'b001, 3'b110,0,1); add(0,1,0,3'b001, 3'b110,0,1);
        add(0,1,0,3'b001, 3'b100,0,1);
        add(0,1,0,3'b001, 3'b100,0,1); add(0,1,0,3'b001, 3'b100,0,1);
        add(0,1,0,3'b011, 3'b100,0,1); add(0,1,0,3'b011, 3'b100,0,1);
        add(0,1,0,3'b011, 3'b000,0,1);
        add(0,1,0,3'b011, 3'b000,0,1); add(0,1,0,3'b011, 3'b000,0,1);
        add(0,1,0,3'b111, 3'b000,1,0); add(0,1,0,3'b111, 3'b000,1,0);
        add(0,1,1,3'b111, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1); add(0,1,0,3'b000, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1);
        add(0,0,0,3'b000, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1); add(0,1,0,3'b000, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1); add(0,1,0,3'b000, 3'b110,0,1);
        add(0,1,0,3'b001, 3'b110,0,1); add(0,1,0,3'b001, 3'b110,0,1);
        add(0,1,0,3'b001, 3'b100,0,1);
        add(0,1,0,3'b011, 3'b100,0,1); add(0,1,0,3'b011, 3'b100,0,1);
        add(0,1,0,3'b011, 3'b000,0,1);
        add(0,1,0,3'b111, 3'b000,1,0);
        add(0,1,0,3'b101, 3'b111,0,1);
        add(0,1,0,3'b000, 3'b111,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].lock, vecs[i].req, vecs[i].ack);
            check($sformatf("vec%0d", i), obs(),
                  {vecs[i].exp_rst, vecs[i].exp_ready, vecs[i].exp_busy, 3'b000});
        end

        // Stage 1 never acknowledges.
        drive(1,1,0,3'b000);
        check("to_reset", obs(), 8'b111_0_1_0_00);
        for (int i = 0; i < HOLD; i++) drive(0,1,0,3'b000);
        check("to_rel0", obs(), 8'b110_0_1_0_00);
        drive(0,1,0,3'b001);
        drive(0,1,0,3'b001);
        drive(0,1,0,3'b001);
        check("to_rel1", obs(), 8'b100_0_1_0_00);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive(0,1,0,3'b001);
            if (k == TIMEOUT - 1) check("to_prefault", obs(), 8'b100_0_1_0_00);
        end
        check("to_fault", obs(), 8'b111_0_0_1_01);
        for (int k = 0; k < 6; k++) begin
            drive(0, logic'(k % 2), 0, 3'b000);
            check($sformatf("to_lock%0d", k), obs(), 8'b111_0_0_1_01);
        end
        drive(0,1,1,3'b000);
        check("to_exit", obs(), 8'b111_0_1_0_00);
        drive(0,1,0,3'b000);
        check("to_hold", obs(), 8'b111_0_1_0_00);
`else
        for (int k = 1; k <= 100; k++) begin
            drive(0,1,0,3'b001);
            if (k == TIMEOUT) check("to_nofault16", obs(), 8'b100_0_1_0_00);
        end
        check("to_nofault100", obs(), 8'b100_0_1_0_00);
        drive(0,1,0,3'b011);
        drive(0,1,0,3'b011);
        check("late_gap", obs(), 8'b100_0_1_0_00);
        drive(0,1,0,3'b011);
        check("late_rel2", obs(), 8'b000_0_1_0_00);
        drive(0,1,0,3'b111);
        check("late_run", obs(), 8'b000_1_0_0_00);
`endif

        // Randomized run against the reference model.
        ack_r = '0;
        for (int i = 0; i < 3000; i++) begin
            logic r, l, q;
            r = (i == 0) || ($urandom_range(99) == 0);
            l = ($urandom_range(99) >= 3);
            q = ($urandom_range(199) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(99) < 15) ack_r[b] = ~ack_r[b];
            end
            drive(r, l, q, ack_r);
            model_step(r, l, q, ack_r);
            check($sformatf("rand%0d", i), obs(), model_obs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
